// File: rtl/sb_config_loader.sv
// sb_config_loader: streams IN_WIDTH-bit words into a CONF_WIDTH staging
// register, then issues a single-cycle commit strobe (cset) to a switch box.
// An idle watchdog aborts a stalled load with a sticky err flag.
module sb_config_loader #(
    parameter int unsigned W          = 8,
    parameter int unsigned CONF_WIDTH = 6 * W,
    parameter int unsigned IN_WIDTH   = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    output logic [CONF_WIDTH-1:0] c,
    output logic                  cset,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned NWORDS = (CONF_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
    localparam int unsigned WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    // Timeout counter only ever holds 0..TIMEOUT-1 before the watchdog fires
    localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NWORDS - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [WCNT_W-1:0]       r_wcnt;
    logic [TCNT_W-1:0]       r_tcnt;
    logic [CONF_WIDTH-1:0]   r_c;
    logic [CONF_WIDTH-1:0]   w_c_next;
    logic                    r_err;
    logic                    w_xfer;
    logic                    w_last;
    logic                    w_tout;
    logic                    w_launch;
    logic                    w_in_ready;
    logic                    w_cset;
    logic                    w_busy;
    logic                    w_done;

    // Abort outranks a same-cycle transfer; a transfer outranks the watchdog
    assign w_xfer   = (r_state == S_LOAD) && in_valid && !abort;
    assign w_last   = (r_wcnt == LAST_WORD);
    assign w_tout   = (r_state == S_LOAD) && !w_xfer && !abort && (r_tcnt == TCNT_MAX);
    assign w_launch = (r_state == S_IDLE) && start && !abort;

    // Per-bit write steering: bit j belongs to word j/IN_WIDTH; bits past CONF_WIDTH never exist
    for (genvar gj = 0; gj < CONF_WIDTH; gj++) begin : g_bit
        localparam int unsigned K = gj / IN_WIDTH;
        localparam int unsigned B = gj % IN_WIDTH;
        assign w_c_next[gj] = (w_xfer && (r_wcnt == WCNT_W'(K))) ? in_data[B] : r_c[gj];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_xfer && w_last) begin
                    w_state_next = S_COMMIT;
                end else if (w_tout) begin
                    w_state_next = S_IDLE;
                end
            end
            S_COMMIT: w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Moore output decode from the state register
    always_comb begin
        w_in_ready = 1'b0;
        w_cset     = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            S_COMMIT: begin
                w_cset = 1'b1;
                w_busy = 1'b1;
            end
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Staging register, word/idle counters and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c    <= '0;
            r_wcnt <= '0;
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_c <= w_c_next;
            if (w_launch) begin
                r_wcnt <= '0;
                r_tcnt <= '0;
                r_err  <= 1'b0;
            end else if (w_xfer) begin
                r_wcnt <= w_last ? '0 : r_wcnt + WCNT_W'(1);
                r_tcnt <= '0;
            end else if (w_tout) begin
                r_tcnt <= '0;
                r_err  <= 1'b1;
            end else if ((r_state == S_LOAD) && !abort) begin
                r_tcnt <= r_tcnt + TCNT_W'(1);
            end
        end
    end

    assign in_ready = w_in_ready;
    assign cset     = w_cset;
    assign busy     = w_busy;
    assign done     = w_done;
    assign c        = r_c;
    assign err      = r_err;

endmodule

// File: tb/tb_sb_config_loader.sv
// Scoreboard bench for sb_config_loader: two instances (8-bit words / TIMEOUT 255,
// and 7-bit words / TIMEOUT 4). Drivers push expected commit values into queues;
// monitors pop and compare on every cset.
module tb_sb_config_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: 8-bit words, 6 words per load
    logic        a_start, a_abort, a_in_valid, a_in_ready, a_cset, a_busy, a_done, a_err;
    logic [7:0]  a_in_data;
    logic [47:0] a_c;
    // Instance B: 7-bit words, 7 words per load, short watchdog
    logic        b_start, b_abort, b_in_valid, b_in_ready, b_cset, b_busy, b_done, b_err;
    logic [6:0]  b_in_data;
    logic [47:0] b_c;

    sb_config_loader #(.W(8), .IN_WIDTH(8), .TIMEOUT(255)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .c(a_c), .cset(a_cset), .busy(a_busy), .done(a_done), .err(a_err)
    );

    sb_config_loader #(.W(8), .CONF_WIDTH(48), .IN_WIDTH(7), .TIMEOUT(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .c(b_c), .cset(b_cset), .busy(b_busy), .done(b_done), .err(b_err)
    );

    // Reference model: expected staging contents and next word index per instance
    logic [47:0] ma, mb;
    int          ka, kb;
    logic [47:0] qa[$];
    logic [47:0] qb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Word k of width iw lands at bit k*iw; anything above bit 47 falls off
    function automatic logic [47:0] put_word(input logic [47:0] cur, input int k,
                                             input int iw, input logic [7:0] d);
        logic [95:0] mask, val, res;
        mask = ((96'd1 << iw) - 96'd1) << (k * iw);
        val  = (96'(d) & ((96'd1 << iw) - 96'd1)) << (k * iw);
        res  = (96'(cur) & ~mask) | val;
        return res[47:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input bit sel);
        if (!sel) begin
            a_start = 1'b1; tick(); a_start = 1'b0; ka = 0;
            chk("a_busy_after_start", 64'(a_busy), 64'd1);
        end else begin
            b_start = 1'b1; tick(); b_start = 1'b0; kb = 0;
            chk("b_busy_after_start", 64'(b_busy), 64'd1);
        end
    endtask

    // Idle for gap cycles, then offer one word and hold it until accepted
    task automatic push(input bit sel, input logic [7:0] d, input int gap);
        int n;
        repeat (gap) tick();
        n = 0;
        if (!sel) begin
            a_in_valid = 1'b1; a_in_data = d;
            while (!a_in_ready && n < 20) begin tick(); n++; end
            if (!a_in_ready) begin
                chk("a_ready_wait", 64'd0, 64'd1);
                a_in_valid = 1'b0;
                return;
            end
            tick();
            a_in_valid = 1'b0;
            ma = put_word(ma, ka, 8, d);
            if (ka == 5) begin qa.push_back(ma); ka = 0; end else ka++;
        end else begin
            b_in_valid = 1'b1; b_in_data = d[6:0];
            while (!b_in_ready && n < 20) begin tick(); n++; end
            if (!b_in_ready) begin
                chk("b_ready_wait", 64'd0, 64'd1);
                b_in_valid = 1'b0;
                return;
            end
            tick();
            b_in_valid = 1'b0;
            mb = put_word(mb, kb, 7, d);
            if (kb == 6) begin qb.push_back(mb); kb = 0; end else kb++;
        end
    endtask

    // Present a word together with abort: the word must be dropped
    task automatic abort_with(input bit sel, input logic [7:0] d);
        if (!sel) begin
            a_in_valid = 1'b1; a_in_data = d; a_abort = 1'b1;
            tick();
            a_in_valid = 1'b0; a_abort = 1'b0;
            chk("a_busy_after_abort", 64'(a_busy), 64'd0);
            chk("a_ready_after_abort", 64'(a_in_ready), 64'd0);
        end else begin
            b_in_valid = 1'b1; b_in_data = d[6:0]; b_abort = 1'b1;
            tick();
            b_in_valid = 1'b0; b_abort = 1'b0;
            chk("b_busy_after_abort", 64'(b_busy), 64'd0);
        end
    endtask

    // Monitor A: every cset must match a queued commit; done follows one cycle later
    bit a_prev_cset = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            a_prev_cset = 1'b0;
        end else begin
            if (a_cset) begin
                if (qa.size() == 0) begin
                    chk("a_cset_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("a_commit_c", 64'(a_c), 64'(qa.pop_front()));
                end
                chk("a_ready_in_commit", 64'(a_in_ready), 64'd0);
                chk("a_busy_in_commit", 64'(a_busy), 64'd1);
            end
            if (a_prev_cset || a_done) begin
                chk("a_done_after_cset", 64'(a_done), 64'(a_prev_cset));
                if (a_done) chk("a_busy_in_done", 64'(a_busy), 64'd0);
            end
            a_prev_cset = a_cset;
        end
    end

    // Monitor B
    bit b_prev_cset = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            b_prev_cset = 1'b0;
        end else begin
            if (b_cset) begin
                if (qb.size() == 0) begin
                    chk("b_cset_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("b_commit_c", 64'(b_c), 64'(qb.pop_front()));
                end
                chk("b_ready_in_commit", 64'(b_in_ready), 64'd0);
            end
            if (b_prev_cset || b_done) begin
                chk("b_done_after_cset", 64'(b_done), 64'(b_prev_cset));
            end
            b_prev_cset = b_cset;
        end
    end

    // Global watchdog so the run can never hang
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seq[6];
        int         abort_at;
        bit         aborted;

        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rst = 1'b1;
        a_start = 0; a_abort = 0; a_in_valid = 0; a_in_data = '0;
        b_start = 0; b_abort = 0; b_in_valid = 0; b_in_data = '0;
        ma = '0; mb = '0; ka = 0; kb = 0;

        // Reset state
        repeat (3) tick();
        chk("rst_c", 64'(a_c), 64'd0);
        chk("rst_outputs", 64'({a_cset, a_done, a_busy, a_err, a_in_ready}), 64'd0);
        chk("rst_b_outputs", 64'({b_c, b_cset, b_done, b_busy, b_err, b_in_ready}), 64'd0);
        rst = 1'b0;
        tick();

        // Back-to-back load
        start_load(0);
        for (int i = 0; i < 6; i++) push(0, seq[i], 0);
        chk("b2b_model", 64'(ma), 64'h665544332211);
        repeat (3) tick();
        chk("b2b_c", 64'(a_c), 64'h665544332211);
        chk("b2b_err", 64'(a_err), 64'd0);

        // Gapped load with three idle cycles before each word
        start_load(0);
        for (int i = 0; i < 6; i++) push(0, seq[i], 3);
        repeat (3) tick();
        chk("gap_c", 64'(a_c), 64'h665544332211);
        chk("gap_err", 64'(a_err), 64'd0);

        // abort in IDLE blocks a simultaneous start
        a_start = 1'b1; a_abort = 1'b1; tick();
        a_start = 1'b0; a_abort = 1'b0;
        chk("idle_abort_blocks_start", 64'({a_busy, a_in_ready}), 64'd0);
        tick();
        chk("idle_abort_stays_idle", 64'(a_busy), 64'd0);

        // start held high through LOAD and COMMIT must not restart the load
        a_start = 1'b1; tick(); ka = 0;
        for (int i = 0; i < 6; i++) push(0, 8'(8'hA0 + i), (i == 2) ? 2 : 0);
        tick();
        chk("held_start_done", 64'(a_done), 64'd1);
        a_start = 1'b0;
        tick();
        chk("held_start_idle", 64'({a_busy, a_in_ready}), 64'd0);
        chk("held_start_c", 64'(a_c), 64'(ma));

        // Synchronous reset in the middle of a load
        start_load(0);
        push(0, 8'h5A, 0);
        push(0, 8'hC3, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        ma = '0; mb = '0; ka = 0;
        chk("midrst_c", 64'(a_c), 64'd0);
        chk("midrst_outputs", 64'({a_cset, a_done, a_busy, a_err, a_in_ready}), 64'd0);
        repeat (3) tick();
        chk("midrst_still_idle", 64'(a_busy), 64'd0);

        // abort presented with word 3: first three words kept, word 3 dropped
        start_load(0);
        for (int i = 0; i < 3; i++) push(0, seq[i], 0);
        abort_with(0, 8'h44);
        repeat (3) tick();
        chk("abort_c", 64'(a_c), 64'h000000332211);
        chk("abort_err", 64'(a_err), 64'd0);

        // Randomised loads with random gaps and occasional aborts
        for (int l = 0; l < 25; l++) begin
            start_load(0);
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            aborted  = 1'b0;
            for (int w = 0; w < 6; w++) begin
                if (w == abort_at) begin
                    abort_with(0, 8'($urandom));
                    aborted = 1'b1;
                    break;
                end
                push(0, 8'($urandom), int'($urandom_range(0, 3)));
            end
            repeat (3) tick();
            chk(aborted ? "rand_abort_c" : "rand_c", 64'(a_c), 64'(ma));
            chk("rand_err", 64'(a_err), 64'd0);
            repeat ($urandom_range(0, 2)) tick();
        end

        // 7-bit words: seven all-ones words fill 48 bits, top bit of last word dropped
        start_load(1);
        for (int i = 0; i < 7; i++) push(1, 8'h7F, 0);
        repeat (3) tick();
        chk("w7_c", 64'(b_c), 64'hFFFFFFFFFFFF);
        chk("w7_err", 64'(b_err), 64'd0);

        // Watchdog: two words then silence; IDLE after exactly four idle cycles
        start_load(1);
        push(1, 8'h01, 0);
        push(1, 8'h02, 0);
        repeat (3) tick();
        chk("tout_still_busy", 64'({b_busy, b_err}), 64'b10);
        tick();
        chk("tout_idle_err", 64'({b_busy, b_err, b_in_ready}), 64'b010);
        repeat (3) tick();
        chk("tout_err_sticky", 64'(b_err), 64'd1);
        chk("tout_partial_c", 64'(b_c), 64'(mb));

        // Next start clears err; gaps of three stay just under the watchdog
        start_load(1);
        chk("restart_clears_err", 64'(b_err), 64'd0);
        for (int i = 0; i < 7; i++) push(1, 8'($urandom), 3);
        repeat (3) tick();
        chk("tout_boundary_c", 64'(b_c), 64'(mb));
        chk("tout_boundary_err", 64'(b_err), 64'd0);

        // Randomised 7-bit loads
        for (int l = 0; l < 8; l++) begin
            start_load(1);
            for (int w = 0; w < 7; w++) push(1, 8'($urandom), int'($urandom_range(0, 3)));
            repeat (3) tick();
            chk("rand_b_c", 64'(b_c), 64'(mb));
        end

        repeat (4) tick();
        chk("a_queue_drained", 64'(qa.size()), 64'd0);
        chk("b_queue_drained", 64'(qb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sb_config_loader.md
SB_CONFIG_LOADER -- requirements
Module: sb_config_loader

Interface
REQ-001 SHALL have parameter W, default 8: fabric wires per side of the configured switch box.
REQ-002 SHALL have parameter CONF_WIDTH, default 6*W: configuration word width, 6 bits per switch element.
REQ-003 SHALL have parameter IN_WIDTH, default 8: width of one streamed configuration word.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum idle cycles allowed between accepted words during LOAD.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  request to begin a load.
REQ-008 SHALL have port abort  input  1  cancel an in-progress load.
REQ-009 SHALL have port in_valid  input  1  in_data holds a valid word.
REQ-010 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-011 SHALL have port in_data  input  IN_WIDTH  configuration word.
REQ-012 SHALL have port c  output  CONF_WIDTH  assembled staging register, direct register output.
REQ-013 SHALL have port cset  output  1  one-cycle commit strobe to the switch box.
REQ-014 SHALL have port busy  output  1  high in LOAD and COMMIT.
REQ-015 SHALL have port done  output  1  one-cycle pulse after a successful commit.
REQ-016 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-017 SHALL define NWORDS = ceil(CONF_WIDTH/IN_WIDTH); excess bits of the final word are discarded.
REQ-018 SHALL implement FSM states IDLE, LOAD, COMMIT, DONE.
REQ-019 IDLE: in_ready=0; start=1 and abort=0 -> LOAD next cycle, word counter=0, timeout counter=0, err cleared.
REQ-020 LOAD: in_ready=1; word transfer occurs only on in_valid&in_ready.
REQ-021 Accepted word k (0-based) SHALL be written into c[k*IN_WIDTH +: IN_WIDTH], clipped to CONF_WIDTH; other bits of c hold.
REQ-022 On acceptance of word NWORDS-1, FSM -> COMMIT next cycle; in_ready SHALL be 0 from that cycle on.
REQ-023 COMMIT: cset=1 for exactly one cycle, c stable; -> DONE.
REQ-024 DONE: done=1 for one cycle, busy=0; -> IDLE.
REQ-025 Latency: last word accepted at cycle M -> cset high at M+1, done high at M+2, in_ready earliest high again at M+4 (start at M+3).
REQ-026 Timeout counter SHALL increment each LOAD cycle without a transfer and clear on transfer; reaching TIMEOUT -> IDLE, err=1, no cset.
REQ-027 abort=1 in LOAD -> IDLE next cycle, no cset, no done, err unchanged, partial data left in c.
REQ-028 abort SHALL be ignored in COMMIT and DONE; in IDLE abort=1 blocks start the same cycle.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 Transfer and abort in the same LOAD cycle: abort wins, word not counted.
REQ-031 Transfer and timeout in the same cycle: transfer wins, counter clears.
REQ-032 cset SHALL never assert except from COMMIT; never two cset pulses per start.

Reset
REQ-033 rst SHALL force IDLE, c=0, word and timeout counters=0, cset=0, done=0, busy=0, err=0, in_ready=0.
REQ-034 rst during LOAD or COMMIT SHALL cancel the load with no cset the following cycle.

Verification
REQ-035 W=8, IN_WIDTH=8: start, then words 0x11,0x22,0x33,0x44,0x55,0x66 back-to-back -> cset one cycle with c=48'h665544332211, done next cycle.
REQ-036 Same load with in_valid gapped 3 cycles between words, TIMEOUT=255 -> identical c and single cset, no err.
REQ-037 TIMEOUT=4: start, 2 words, then in_valid=0 -> IDLE after 4 idle cycles, err=1, cset never asserted; next start clears err.
REQ-038 abort asserted with word 3 valid -> IDLE, no cset/done, c[23:0]=24'h332211 retained, c[31:24] unchanged.
REQ-039 start held high during LOAD/COMMIT/DONE and rst mid-LOAD -> no second load starts, rst clears c to 0 and all outputs low.
REQ-040 IN_WIDTH=7, CONF_WIDTH=48: 7 words of 7'h7F -> c=48'hFFFFFFFFFFFF, top bit of final word dropped.
